// File: rtl/joy_serial_rx.sv
// Reader for a daisy-chained 74HC165-style parallel-in/serial-out chain.
// Generates LOAD and serial clock from a divided tick, shifts in a frame, debounces it.
module joy_serial_rx #(
    parameter int DIV   = 8,
    parameter int NCH   = 2,
    parameter int NBITS = 12,
    parameter int LEAD  = 1,
    parameter int GAP   = 0,
    parameter int INV   = 1,
    parameter int DEB   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   joy_data,
    output logic                   joy_clk,
    output logic                   joy_load,
    output logic [NCH*NBITS-1:0]   joy_out,
    output logic                   frame_stb,
    output logic                   busy
);
    localparam int NB        = NCH * NBITS;
    localparam int FRAME_PER = 1 + LEAD + NB + GAP;
    localparam int CW        = $clog2(FRAME_PER + 1);
    localparam int DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW        = (DEB > 1) ? $clog2(DEB) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [CW-1:0] LEAD_LAST  = CW'((LEAD > 0) ? LEAD - 1 : 0);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(NB - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LEAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            joy_clk_q, joy_clk_d;
    logic            joy_load_q, joy_load_d;
    logic [NB-1:0]   shift_q, shift_d;
    logic            stb_q, stb_d;
    logic [NB-1:0]   cand_q, cand_d;
    logic [BW-1:0]   deb_q, deb_d;
    logic [NB-1:0]   out_q, out_d;

    logic            tick;
    logic            rise;
    logic            fall;
    logic            frame_end;
    logic [NB-1:0]   shift_in;
    logic [NB-1:0]   frame_val;

    // Samples enter at the MSB and move down, so the first sample ends up in bit 0.
    generate
        if (NB == 1) begin : g_shift_one
            assign shift_in = joy_data;
        end else begin : g_shift_many
            assign shift_in = {joy_data, shift_q[NB-1:1]};
        end
    endgenerate

    assign frame_val = (INV != 0) ? ~shift_q : shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
            shift_q    <= '0;
            stb_q      <= 1'b0;
            cand_q     <= '0;
            deb_q      <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            shift_q    <= shift_d;
            stb_q      <= stb_d;
            cand_q     <= cand_d;
            deb_q      <= deb_d;
            out_q      <= out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        joy_clk_d  = joy_clk_q;
        joy_load_d = joy_load_q;
        shift_d    = shift_q;
        stb_d      = 1'b0;
        frame_end  = 1'b0;

        tick = (state_q != S_IDLE) && (div_q == DIV_LAST);
        rise = tick && !joy_clk_q;
        fall = tick && joy_clk_q;

        if (state_q == S_IDLE) begin
            div_d      = '0;
            joy_clk_d  = 1'b0;
            joy_load_d = 1'b1;
            if (en) begin
                state_d    = S_LOAD;
                joy_load_d = 1'b0;
                cnt_d      = '0;
            end
        end else begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) begin
                joy_clk_d = ~joy_clk_q;
            end
        end

        case (state_q)
            S_LOAD: begin
                if (fall) begin
                    joy_load_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = (LEAD > 0) ? S_LEAD : S_SHIFT;
                end
            end
            S_LEAD: begin
                if (fall) begin
                    if (cnt_q == LEAD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_SHIFT: begin
                if (rise) begin
                    shift_d = shift_in;
                    stb_d   = (cnt_q == SHIFT_LAST);
                end
                if (fall) begin
                    if (cnt_q == SHIFT_LAST) begin
                        cnt_d = '0;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_GAP: begin
                if (fall) begin
                    if (cnt_q == GAP_LAST) begin
                        frame_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase

        // End-of-frame decision is folded into the last falling tick, so a
        // restart begins LOAD on the very next period with no idle gap.
        if (frame_end) begin
            cnt_d = '0;
            if (en) begin
                state_d    = S_LOAD;
                joy_load_d = 1'b0;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        cand_d = cand_q;
        deb_d  = deb_q;
        out_d  = out_q;
        if (stb_q) begin
            if (frame_val == cand_q) begin
                if (deb_q != DEB_LAST) begin
                    deb_d = deb_q + BW'(1);
                end
            end else begin
                cand_d = frame_val;
                deb_d  = '0;
            end
            if (deb_d == DEB_LAST) begin
                out_d = cand_d;
            end
        end
    end

    assign joy_clk   = joy_clk_q;
    assign joy_load  = joy_load_q;
    assign joy_out   = out_q;
    assign frame_stb = stb_q;
    assign busy      = (state_q != S_IDLE);

endmodule
